// File: rtl/uart_tx_sched_pkg.sv
// Shared constants for the UART transmit scheduler: FSM encodings, grant width, pointer helper.
package uart_tx_sched_pkg;

  localparam int unsigned GrantW = 2;

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StLoad = 1'b1;

  // Round-robin successor of a grant index, wrapping at num_req.
  function automatic logic [GrantW-1:0] rr_next(input logic [GrantW-1:0] id,
                                                input int unsigned      num_req);
    if (32'(id) == num_req - 1) begin
      return '0;
    end
    return id + 1'b1;
  endfunction

endpackage

// File: rtl/uart_tx_rr_pick.sv
// Combinational round-robin picker: first set bit of (valid & lock mask) at or after the pointer.
module uart_tx_rr_pick
  import uart_tx_sched_pkg::*;
#(
  parameter int unsigned NumReq = 3
) (
  input  logic [NumReq-1:0] valid_i,
  input  logic [GrantW-1:0] ptr_i,
  input  logic [NumReq-1:0] lock_mask_i,
  output logic [NumReq-1:0] onehot_o,
  output logic [GrantW-1:0] idx_o,
  output logic              found_o
);

  localparam logic [GrantW:0] NumReqW = (GrantW + 1)'(NumReq);

  logic [NumReq-1:0]   cand;
  logic [2*NumReq-1:0] dbl;
  logic [NumReq-1:0]   rot;
  logic [GrantW-1:0]   off;
  logic [GrantW:0]     sum;
  logic                found;

  always_comb begin
    cand  = valid_i & lock_mask_i;
    // Rotate so that the pointer position lands on bit 0.
    dbl   = {cand, cand} >> ptr_i;
    rot   = dbl[NumReq-1:0];
    found = 1'b0;
    off   = '0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      if (!found && rot[i]) begin
        found = 1'b1;
        off   = GrantW'(i);
      end
    end
    sum = {1'b0, ptr_i} + {1'b0, off};
    if (sum >= NumReqW) begin
      sum = sum - NumReqW;
    end
    idx_o    = sum[GrantW-1:0];
    onehot_o = found ? (NumReq'(1) << idx_o) : '0;
    found_o  = found;
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin byte scheduler feeding a UART transmitter through a one-entry holding register.
// Define UART_TX_SCHED_LOCK_EN to compile in burst locking with an idle timeout.
module uart_tx_sched
  import uart_tx_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ      = 3,
  parameter int unsigned LOCK_TIMEOUT = 4096
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ-1:0]   req_lock,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [7:0]           tx_data,
  output logic                 tx_avail,
  input  logic                 tx_ready,
  output logic [GrantW-1:0]    grant_id,
  output logic                 lock_active
);

  logic [0:0]         state_q, state_d;
  logic [7:0]         tx_data_q, tx_data_d;
  logic [GrantW-1:0]  grant_q, grant_d;
  logic [GrantW-1:0]  ptr, pick_idx;
  logic [NUM_REQ-1:0] lock_mask, pick_oh;
  logic               found, accept;
  logic [7:0]         pick_byte;

  assign ptr = rr_next(grant_q, NUM_REQ);

  uart_tx_rr_pick #(
    .NumReq (NUM_REQ)
  ) u_pick (
    .valid_i     (req_valid),
    .ptr_i       (ptr),
    .lock_mask_i (lock_mask),
    .onehot_o    (pick_oh),
    .idx_o       (pick_idx),
    .found_o     (found)
  );

  assign accept = !rst && (state_q == StIdle) && found;

  always_comb begin
    pick_byte = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (pick_oh[i]) begin
        pick_byte = pick_byte | req_data[8*i +: 8];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    tx_data_d = tx_data_q;
    grant_d   = grant_q;
    if (state_q == StIdle) begin
      if (accept) begin
        state_d   = StLoad;
        tx_data_d = pick_byte;
        grant_d   = pick_idx;
      end
    end else if (tx_ready) begin
      state_d = StIdle;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      tx_data_q <= 8'h00;
      grant_q   <= GrantW'(NUM_REQ - 1);
    end else begin
      state_q   <= state_d;
      tx_data_q <= tx_data_d;
      grant_q   <= grant_d;
    end
  end

`ifdef UART_TX_SCHED_LOCK_EN
  localparam int unsigned CntW = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;

  logic [NUM_REQ-1:0] grant_oh;
  logic               lock_q, lock_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic               lock_hold, grant_valid;

  assign grant_oh    = NUM_REQ'(1) << grant_q;
  // A lock only narrows arbitration while its owner still asserts req_lock.
  assign lock_hold   = lock_q && |(req_lock & grant_oh);
  assign grant_valid = |(req_valid & grant_oh);
  assign lock_mask   = lock_hold ? grant_oh : '1;

  always_comb begin
    lock_d = lock_q;
    cnt_d  = cnt_q;
    if (state_q == StIdle) begin
      if (accept) begin
        lock_d = |(req_lock & pick_oh);
        cnt_d  = '0;
      end else if (lock_q && !lock_hold) begin
        lock_d = 1'b0;
        cnt_d  = '0;
      end else if (lock_q && !grant_valid) begin
        if (cnt_q == CntW'(LOCK_TIMEOUT - 1)) begin
          lock_d = 1'b0;
          cnt_d  = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lock_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      lock_q <= lock_d;
      cnt_q  <= cnt_d;
    end
  end

  assign lock_active = lock_q;
`else
  logic unused_cfg;

  assign unused_cfg  = ^req_lock ^ (LOCK_TIMEOUT == 0);
  assign lock_mask   = '1;
  assign lock_active = 1'b0;
`endif

  assign req_ready = accept ? pick_oh : '0;
  assign tx_avail  = (state_q == StLoad);
  assign tx_data   = tx_data_q;
  assign grant_id  = grant_q;

endmodule

// File: doc/uart_tx_sched.md
UART_TX_SCHED -- requirements
Module: uart_tx_sched

Interface
REQ-001 Parameter NUM_REQ, default 3: number of byte requesters (2..4).
REQ-002 Parameter LOCK_TIMEOUT, default 4096: idle cycles before a held lock is dropped.
REQ-003 clk  input  1  single clock; all logic on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 req_data  input  8*NUM_REQ  byte from requester i, at bits [8i+7:8i].
REQ-006 req_valid  input  NUM_REQ  requester i has a byte pending.
REQ-007 req_lock  input  NUM_REQ  requester i asks to keep the grant between bytes (used only with the lock feature).
REQ-008 req_ready  output  NUM_REQ  one-cycle accept pulse; the byte is taken on that cycle.
REQ-009 tx_data  output  8  byte to the UART transmitter.
REQ-010 tx_avail  output  1  byte on tx_data is valid for the transmitter.
REQ-011 tx_ready  input  1  transmitter idle; a byte is taken when tx_avail and tx_ready are both high.
REQ-012 grant_id  output  2  index of the last accepted requester.
REQ-013 lock_active  output  1  a lock is currently held (0 when the feature is compiled out).

Function
REQ-014 The FSM SHALL have two states: IDLE (holding register empty) and LOAD (byte held, tx_avail=1).
REQ-015 In IDLE with any req_valid set, the block SHALL pick a winner, pulse req_ready[winner] for one cycle, latch the byte into tx_data, set grant_id, and enter LOAD on the next cycle.
REQ-016 Arbitration SHALL be round-robin: search starts at (last grant_id+1) mod NUM_REQ; after reset the pointer makes requester 0 the first candidate.
REQ-017 In LOAD, tx_avail SHALL be 1; on the cycle with tx_ready=1 the FSM SHALL return to IDLE, with tx_avail=0 from the next cycle.
REQ-018 In LOAD, no req_ready SHALL be pulsed and tx_data SHALL stay stable.
REQ-019 A byte accepted while the transmitter is busy SHALL wait in LOAD; steady-state cost is no more than 2 clocks of overhead per byte.
REQ-020 req_ready SHALL never be asserted for a requester whose req_valid is low, and at most one bit SHALL be set per cycle.
REQ-021 A requester that drops req_valid before being granted SHALL be skipped with no side effect.

Reset
REQ-022 When rst is high, the block SHALL set state=IDLE, tx_avail=0, tx_data=8'h00, req_ready=0, grant_id=NUM_REQ-1, lock_active=0 and the timeout counter to 0.
REQ-023 Reset while in LOAD SHALL discard the held byte without sending it; the requester is not re-notified.

Configuration
REQ-024 Macro UART_TX_SCHED_LOCK_EN compiles in burst locking; without it, req_lock is ignored, lock_active=0, and arbitration is pure round-robin.
REQ-025 With the macro defined, an accepted byte whose req_lock bit is 1 SHALL set lock_active, and arbitration SHALL then consider only grant_id.
REQ-026 Lock release SHALL happen when a byte is accepted from the locked requester with req_lock=0, or when req_lock[grant_id] is 0 in IDLE.
REQ-027 The timeout counter SHALL count IDLE cycles with lock_active=1 and req_valid[grant_id]=0, and clear on each accept.
REQ-028 When the timeout counter reaches LOCK_TIMEOUT-1, the lock SHALL release and round-robin SHALL resume on the next cycle.

Structure
REQ-029 A shared package/header SHALL hold the state encodings (IDLE, LOAD) and the grant_id width constant.
REQ-030 The block SHALL contain one sub-module, uart_tx_rr_pick: a combinational round-robin picker taking valid mask, pointer and lock mask, and returning one-hot plus index.
REQ-031 The block SHALL connect to the existing transmitter only through tx_data, tx_avail and tx_ready; it SHALL NOT instantiate the transmitter.

Verification
REQ-032 All three req_valid high from reset, tx_ready=1 -> grants in order 0,1,2,0, with req_ready pulses 2 cycles apart.
REQ-033 Requester 1 sends 8'hA5 while tx_ready=0 for 20 cycles -> tx_avail=1 and tx_data=8'hA5 held for 20 cycles; accepted on the first tx_ready=1 cycle; no other req_ready pulses.
REQ-034 LOCK_EN defined, requester 2 sends 3 bytes with req_lock=1 and req 0 always valid -> bytes from 2 are contiguous, then 0 is granted after 2 drops req_lock.
REQ-035 LOCK_EN defined, LOCK_TIMEOUT=16, locked requester goes silent -> lock_active falls after 16 idle cycles, then the next pending requester is granted.
REQ-036 rst pulsed in LOAD holding 8'h3C -> next cycle tx_avail=0, tx_data=8'h00, grant_id=NUM_REQ-1, and no byte reaches the transmitter.
